// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock
// through a small carry-lookahead slice. Single-entry valid/ready handshake
// on both sides; the result is held in DONE until the consumer takes it.
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK+1:0] cla_res;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic [WIDTH-1:0] sum_nxt;

  // One CHUNK-bit carry-lookahead slice. Returns {carry into the slice MSB,
  // carry out of the slice, slice sum}; the carry into the MSB of the last
  // slice is the carry into bit WIDTH-1, needed for signed overflow.
  function automatic logic [CHUNK+1:0] cla_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK:0]   c;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    for (int k = 0; k < CHUNK; k++) begin
      c[k+1] = g[k] | (p[k] & c[k]);
    end
    return {c[CHUNK-1], c[CHUNK], p ^ c[CHUNK-1:0]};
  endfunction

  // Select the active chunk of each operand and merge its sum into the result.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    cla_res    = cla_chunk(a_chunk, b_chunk, carry);
    chunk_sum  = cla_res[CHUNK-1:0];
    chunk_cout = cla_res[CHUNK];
    chunk_cmsb = cla_res[CHUNK+1];
    sum_nxt    = sum;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CNT_W'(i)) begin
        sum_nxt[i*CHUNK +: CHUNK] = chunk_sum;
      end
    end
  end

  // Operand capture on acceptance; B is pre-inverted for subtraction so the
  // datapath only ever adds.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b ^ {WIDTH{sub}};
    end
  end

  // Control FSM with registered handshake and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry    <= sub ? 1'b1 : cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          carry <= chunk_cout;
          sum   <= sum_nxt;
          if (cnt == LAST) begin
            cout      <= chunk_cout;
            ovf       <= chunk_cmsb ^ chunk_cout;
            zero      <= (sum_nxt == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: five seq_adder instances (CHUNK = 1,2,4,8,16, WIDTH = 16)
// driven in lockstep and checked against a plain-arithmetic reference.
module tb_seq_adder;

  localparam int W  = 16;
  localparam int ND = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready_w  [ND];
  logic         out_valid_w [ND];
  logic         cout_w      [ND];
  logic         ovf_w       [ND];
  logic         zero_w      [ND];
  logic [W-1:0] sum_w       [ND];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    seq_adder #(.WIDTH(W), .CHUNK(1 << gi)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_w[gi]),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .cin      (cin),
      .out_valid(out_valid_w[gi]),
      .out_ready(out_ready),
      .sum      (sum_w[gi]),
      .cout     (cout_w[gi]),
      .ovf      (ovf_w[gi]),
      .zero     (zero_w[gi])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Reference result packed as {zero, ovf, cout, sum}.
  function automatic logic [W+2:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s, input logic ci);
    logic [W:0]   r;
    logic [W-1:0] sm;
    logic         co;
    logic         ov;
    if (s) begin
      r  = {1'b0, x} - {1'b0, y};
      sm = r[W-1:0];
      co = (x >= y);
      ov = (x[W-1] != y[W-1]) && (sm[W-1] != x[W-1]);
    end else begin
      r  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      sm = r[W-1:0];
      co = r[W];
      ov = (x[W-1] == y[W-1]) && (sm[W-1] != x[W-1]);
    end
    return {(sm == '0), ov, co, sm};
  endfunction

  // Transaction-level model: one outstanding op per instance, result due
  // NCHUNK edges after acceptance.
  int           cyc = 0;
  bit           busy [ND] = '{default: 1'b0};
  bit           clr  [ND] = '{default: 1'b1};
  int           due  [ND] = '{default: 0};
  logic [W+2:0] exp_r [ND];
  logic [W+2:0] mr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ND; k++) begin
        busy[k] = 1'b0;
        clr[k]  = 1'b1;
      end
    end else begin
      cyc = cyc + 1;
      mr  = ref_op(a, b, sub, cin);
      for (int k = 0; k < ND; k++) begin
        if (!busy[k]) begin
          if (in_valid) begin
            busy[k]  = 1'b1;
            clr[k]   = 1'b0;
            due[k]   = cyc + (W >> k);
            exp_r[k] = mr;
          end
        end else if (cyc > due[k] && out_ready) begin
          busy[k] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (!busy[k]) begin
        chk("in_ready_idle", k, in_ready_w[k], 1);
        chk("out_valid_idle", k, out_valid_w[k], 0);
        if (clr[k]) begin
          chk("sum_rst", k, sum_w[k], 0);
          chk("flags_rst", k, {cout_w[k], ovf_w[k], zero_w[k]}, 0);
        end
      end else if (cyc < due[k]) begin
        chk("in_ready_run", k, in_ready_w[k], 0);
        chk("out_valid_run", k, out_valid_w[k], 0);
      end else begin
        chk("out_valid_done", k, out_valid_w[k], 1);
        chk("in_ready_done", k, in_ready_w[k], 0);
        chk("sum", k, sum_w[k], exp_r[k][W-1:0]);
        chk("cout", k, cout_w[k], exp_r[k][W]);
        chk("ovf", k, ovf_w[k], exp_r[k][W+1]);
        chk("zero", k, zero_w[k], exp_r[k][W+2]);
      end
    end
  end

  // Issue one op with all instances idle, scramble inputs while in flight,
  // check literal results and latency, hold in DONE, then release.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input logic xc,
                        input logic [W-1:0] es, input logic ec, input logic eo, input logic ez,
                        input int hold, input string nm);
    int lat [ND];
    bit done;
    chk({nm, "_model"}, 0, ref_op(xa, xb, xs, xc), {ez, eo, ec, es});
    for (int k = 0; k < ND; k++) lat[k] = -1;
    in_valid = 1'b1; a = xa; b = xb; sub = xs; cin = xc;
    @(posedge clk); #1;
    for (int i = 1; i <= 40; i++) begin
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
      sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      done = 1'b1;
      for (int k = 0; k < ND; k++) begin
        if (out_valid_w[k] && lat[k] < 0) lat[k] = i;
        if (lat[k] < 0) done = 1'b0;
      end
      if (done) break;
    end
    for (int k = 0; k < ND; k++) begin
      chk({nm, "_latency"}, k, lat[k], W >> k);
      chk({nm, "_sum"}, k, sum_w[k], es);
      chk({nm, "_flags"}, k, {cout_w[k], ovf_w[k], zero_w[k]}, {ec, eo, ez});
    end
    repeat (hold) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < ND; k++) chk({nm, "_release"}, k, in_ready_w[k], 1);
  endtask

  initial begin
    logic [W+2:0] r;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rc;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 0, "add_basic");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1, "add_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 0, "add_cin");
    run_op(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0, "sub_zero");
    run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0, "sub_ovf");
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3, "hold_done");

    // Abort an op in flight after the third chunk edge of the CHUNK=4 unit.
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b0; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #3;
    for (int k = 0; k < ND; k++) begin
      chk("abort_out_valid", k, out_valid_w[k], 0);
      chk("abort_in_ready", k, in_ready_w[k], 1);
      chk("abort_sum", k, sum_w[k], 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0, "post_abort");

    repeat (40) begin
      repeat ($urandom_range(0, 2)) begin
        a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
      end
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      r = ref_op(ra, rb, rs, rc);
      run_op(ra, rb, rs, rc, r[W-1:0], r[W], r[W+1], r[W+2], $urandom_range(0, 3), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
